out_splitbuffer: RTL and testbench

OUT_SPLITBUFFER -- requirements
Module: out_splitbuffer

---
 rtl/out_splitbuffer.sv | 165 ++++++++++++++++
 tb/tb_out_splitbuffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/out_splitbuffer.sv
// out_splitbuffer
//   Buffers wide packed result words in a small FIFO and streams each one out
//   as three narrow beats (low slice first) with a valid/ready handshake.
//   A transfer is tx_len wide words long; done pulses after its last beat.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   op_start, tx_len    start a transfer of tx_len wide words (IDLE only)
//   end_conv            abort: back to IDLE, buffer contents discarded
//   in_valid, in_data   wide word push; in_stall tells upstream to hold off
//   out_data/valid/ready/last   narrow beat stream
//   done                one-cycle completion pulse
//   overflow            sticky: a word arrived while the FIFO was full
//   level               FIFO occupancy in wide words
module out_splitbuffer #(
    parameter int IN_WIDTH  = 1536,
    parameter int OUT_WIDTH = 512,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_start,
    input  logic                 end_conv,
    input  logic [15:0]          tx_len,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 in_stall,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 done,
    output logic                 overflow,
    output logic [ADDR_BITS:0]   level
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                r_state, w_next;
    logic [IN_WIDTH-1:0]   r_mem [DEPTH];
    logic [ADDR_BITS-1:0]  r_wptr, r_rptr;
    logic [ADDR_BITS:0]    r_count;
    logic [IN_WIDTH-1:0]   r_hold;
    logic                  r_hold_vld;
    logic [1:0]            r_sel;
    logic [15:0]           r_wcnt, r_len;
    logic                  r_ovf;

    logic w_full, w_empty, w_start, w_stall, w_push, w_hs, w_wrap, w_pop, w_last;

    // Count saturates at DEPTH, so its MSB alone means full.
    assign w_full  = r_count[ADDR_BITS];
    assign w_empty = (r_count == '0);
    assign w_start = op_start & (r_state == S_IDLE) & ~end_conv;
    assign w_stall = (r_state != S_RUN) | w_full;
    assign w_push  = in_valid & ~w_stall;
    assign w_hs    = r_hold_vld & out_ready;
    assign w_wrap  = w_hs & (r_sel == 2'd2);
    // Refill the hold register when it is empty or its last slice is leaving,
    // so consecutive words stream without a bubble.
    assign w_pop   = ~w_empty & (~r_hold_vld | w_wrap);
    assign w_last  = r_hold_vld & (r_sel == 2'd2) & (r_wcnt == r_len - 16'd1);

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // ---- FSM: next state ----
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (op_start) w_next = (tx_len != 16'd0) ? S_RUN : S_DONE;
            S_RUN:   if (w_hs && w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (end_conv) w_next = S_IDLE;
    end

    // ---- FSM: outputs ----
    always_comb begin
        done     = (r_state == S_DONE);
        in_stall = w_stall;
        out_last = w_last;
    end

    // ---- FIFO storage (data only, no reset needed) ----
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (end_conv) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{ADDR_BITS{1'b0}}, w_push} - {{ADDR_BITS{1'b0}}, w_pop};
        end
    end

    // ---- hold register and slice select ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_sel      <= 2'd0;
        end else if (end_conv) begin
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_sel      <= 2'd0;
        end else if (w_pop) begin
            r_hold     <= r_mem[r_rptr];
            r_hold_vld <= 1'b1;
            r_sel      <= 2'd0;
        end else if (w_hs) begin
            if (r_sel == 2'd2) begin
                r_sel      <= 2'd0;
                r_hold_vld <= 1'b0;
            end else begin
                r_sel <= r_sel + 2'd1;
            end
        end
    end

    // ---- transfer bookkeeping ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt <= '0;
            r_len  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (end_conv || w_start) r_wcnt <= '0;
            else if (w_wrap)         r_wcnt <= r_wcnt + 16'd1;
            if (w_start) r_len <= tx_len;
            // Dropped words only count as overflow while a transfer is live.
            if (w_start)                                       r_ovf <= 1'b0;
            else if ((r_state == S_RUN) && in_valid && w_full) r_ovf <= 1'b1;
        end
    end

    always_comb begin
        out_data = '0;
        case (r_sel)
            2'd0:    out_data = r_hold[0*OUT_WIDTH +: OUT_WIDTH];
            2'd1:    out_data = r_hold[1*OUT_WIDTH +: OUT_WIDTH];
            2'd2:    out_data = r_hold[2*OUT_WIDTH +: OUT_WIDTH];
            default: out_data = '0;
        endcase
    end

    assign out_valid = r_hold_vld;
    assign overflow  = r_ovf;
    assign level     = r_count;

endmodule

// File: tb/tb_out_splitbuffer.sv
module tb_out_splitbuffer;
    localparam int IW = 1536;
    localparam int OW = 512;
    localparam int AB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          op_start, end_conv, in_valid, out_ready;
    logic [15:0]   tx_len;
    logic [IW-1:0] in_data;
    logic          in_stall, out_valid, out_last, done, overflow;
    logic [OW-1:0] out_data;
    logic [AB:0]   level;

    int n_chk  = 0;
    int n_fail = 0;

    out_splitbuffer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst_n(rst_n), .op_start(op_start), .end_conv(end_conv),
        .tx_len(tx_len), .in_valid(in_valid), .in_data(in_data),
        .in_stall(in_stall), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .done(done),
        .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] rnd_word();
        logic [IW-1:0] w;
        for (int i = 0; i < IW/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Reference slicing: slice 0 is the low OW bits and goes first.
    function automatic logic [OW-1:0] slc(input logic [IW-1:0] w, input int s);
        return w[s*OW +: OW];
    endfunction

    task automatic start(input int len);
        @(negedge clk);
        tx_len   = 16'(len);
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
    endtask

    // Full transfer against a queue model: len words pushed as upstream allows,
    // every handshake checked against the expected beat sequence.
    task automatic run_xfer(input int len, input int rdy_pct, input int vld_pct);
        logic [IW-1:0] q[$];
        int beats = 0, pushed = 0, cyc = 0;
        bit fin = 0;
        start(len);
        while (!fin && cyc < 3000) begin
            in_valid = (pushed < len) && !in_stall && ($urandom_range(99) < vld_pct);
            if (in_valid) begin
                in_data = rnd_word();
                q.push_back(in_data);
                pushed++;
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            if (out_valid && out_ready) begin
                if (beats/3 < q.size()) chk("beat_data", out_data, slc(q[beats/3], beats%3));
                else                    chk("beat_before_push", 1'b1, 1'b0);
                chk("beat_last", out_last, beats == 3*len-1);
                if (beats == 3*len-1) fin = 1;
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (!fin) chk("xfer_timeout", 1'b0, 1'b1);
        chk("beat_count", beats, 3*len);
        chk("done_pulse", done, 1'b1);
        chk("done_valid_low", out_valid, 1'b0);
        @(negedge clk);
        chk("done_clear", done, 1'b0);
        chk("idle_stall", in_stall, 1'b1);
    endtask

    logic [IW-1:0] w [18];

    initial begin
        rst_n = 1'b0; op_start = 0; end_conv = 0; in_valid = 0; out_ready = 0;
        tx_len = '0; in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_stall", in_stall, 1'b1);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_level", level, 0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_data", out_data, 0);
        rst_n = 1'b1;

        // Two words at full rate.
        run_xfer(2, 100, 100);

        // Single word, downstream stalled: latency and frozen output.
        w[0] = rnd_word();
        start(1);
        in_valid = 1'b1; in_data = w[0]; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_t1", out_valid, 1'b0);
        @(negedge clk);
        chk("lat_t2", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, slc(w[0], 0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            chk("s1_data", out_data, slc(w[0], b));
            chk("s1_last", out_last, b == 2);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("s1_done", done, 1'b1);
        @(negedge clk);
        chk("s1_done_clr", done, 1'b0);

        // Fill to full with downstream stalled: first word sits in hold,
        // then 16 fill the FIFO and the next one is dropped.
        for (int k = 0; k < 18; k++) w[k] = rnd_word();
        start(20);
        out_ready = 1'b0;
        for (int k = 0; k < 18; k++) begin
            in_valid = 1'b1; in_data = w[k];
            if (k == 16) begin
                chk("fill_stall16", in_stall, 1'b0);
                chk("fill_ovf_pre", overflow, 1'b0);
            end
            if (k == 17) begin
                chk("full_level", level, 16);
                chk("full_stall", in_stall, 1'b1);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_level", level, 16);
        out_ready = 1'b1;
        for (int b = 0; b < 51; b++) begin
            chk("drain_valid", out_valid, 1'b1);
            chk("drain_data", out_data, slc(w[b/3], b%3));
            chk("drain_last", out_last, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("drain_empty", out_valid, 1'b0);
        chk("drain_level", level, 0);
        end_conv = 1'b1;
        @(negedge clk);
        end_conv = 1'b0;
        chk("ovf_sticky", overflow, 1'b1);

        // Abort with level 3 and slice 1 showing.
        start(10);
        chk("ovf_clr_start", overflow, 1'b0);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = w[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("ab_level", level, 3);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ab_sel1", out_data, slc(w[0], 1));
        chk("ab_level2", level, 3);
        end_conv = 1'b1;
        @(negedge clk);
        end_conv = 1'b0;
        chk("ab_level0", level, 0);
        chk("ab_valid", out_valid, 1'b0);
        chk("ab_stall", in_stall, 1'b1);
        chk("ab_data", out_data, 0);
        chk("ab_done", done, 1'b0);
        run_xfer(3, 70, 70);

        // Zero-length transfer.
        start(0);
        chk("z_done", done, 1'b1);
        chk("z_valid", out_valid, 1'b0);
        @(negedge clk);
        chk("z_done_clr", done, 1'b0);
        chk("z_idle", in_stall, 1'b1);

        // Randomized transfers.
        for (int i = 0; i < 6; i++)
            run_xfer($urandom_range(1, 8), $urandom_range(30, 100), $urandom_range(30, 100));

        // Reset asserted mid-beat, away from any clock edge.
        start(4);
        in_valid = 1'b1; in_data = rnd_word();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_data", out_data, 0);
        chk("arst_level", level, 0);
        chk("arst_stall", in_stall, 1'b1);
        chk("arst_last", out_last, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_ovf", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_xfer(1, 100, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
